runner_draw_datapath: RTL and testbench
=======================================

# runner_draw_datapath

Pixel-generation datapath driven by the running-man control FSM. Consumes the FSM's strobes (floor draw, sprite load, sprite draw, erase, write enable) and emits one pixel per cycle to the 160x120, 3-bit-colour VGA adapter. Returns the completion flags the FSM branches on: floors done, man done, erase done.

## Interface
- SCREEN_W, 160, visible columns
- SCREEN_H, 120, visible rows
- SPRITE_W, 8, man sprite width (power of 2)
- SPRITE_H, 16, man sprite height (power of 2)
- MAN_X_INIT, 8, reset value of latched man x
- MAN_Y_INIT, 23, reset value of latched man y
- clk  in  1  system clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- drawing_floors  in  1  floor-draw request (level)
- draw_man  in  1  sprite-draw request (level)
- erase  in  1  sprite-box erase request (level)
- writeEn  in  1  pixel advance enable; low = stall
- ld_x, ld_y, ld_man_style  in  1 each  latch man_x_in / man_y_in / man_style_in
- man_x_in  in  8  sprite top-left x
- man_y_in  in  7  sprite top-left y
- man_style_in  in  2  animation frame select
- vga_x  out  8  pixel column
- vga_y  out  7  pixel row
- vga_colour  out  3  pixel colour
- vga_plot  out  1  pixel write strobe
- draw_floors_finish, draw_man_finish, erase_finish  out  1 each  completion levels

## Operation
- Modes, priority drawing_floors > erase > draw_man; none high = IDLE.
- FLOORS: rows 39, 79, 119, columns 0..159; scan column-fast, floor-slow; 480 pixels; colour FLOOR_COLOUR.
- MAN: SPRITE_W x SPRITE_H box at latched (x,y); pixel colour MAN_COLOUR where sprite ROM mask (style,row,col)=1.
- ERASE: same box, every pixel BG_COLOUR, plot=1.
- Scan counter (col, row/floor index) steps only when active mode and writeEn high; writeEn low holds counter and drives vga_plot=0.
- Pixel coordinate = latched base + offset, computed 9-bit/8-bit; x>=SCREEN_W or y>=SCREEN_H -> vga_plot=0, counter still steps (clip).
- After last coordinate issued, counter freezes, mode finish flag set; held until that mode's request drops.
- Request low -> counter cleared, finish cleared next edge; re-asserting restarts scan from offset 0.
- Mode change mid-scan (higher priority request rises) -> counter cleared, new mode starts at offset 0.
- ld_x/ld_y/ld_man_style latch independently when high; ignored while draw_man or erase high (box frozen during scan).

## Timing
- Reset: vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, all finish=0, counters=0, latches=MAN_X_INIT/MAN_Y_INIT/style 0.
- All outputs registered. Request and writeEn first sampled high at edge 0 -> pixel 0 on outputs after edge 1; pixel i after edge i+1 (no stalls).
- Finish asserts coincident with last pixel: floors after edge 480, man/erase after edge 128 (defaults).
- Each writeEn-low cycle delays all subsequent pixels and finish by one cycle.
- Finish deasserts on first edge sampling request low; vga_plot 0 same edge.
- reset_n low mid-scan: immediate return to reset values; no partial finish.

## Configuration
- MAN_TRANSPARENCY_EN defined: mask-0 sprite pixels produce vga_plot=0 (background preserved).
- Undefined: mask-0 pixels plotted with BG_COLOUR; plot count per man draw = full box.

## Structure
- Package runner_pkg: SCREEN_W/H, FLOOR_ROW0..2, FLOOR_COLOUR=3'b010, MAN_COLOUR=3'b111, BG_COLOUR=3'b000, mode enum (IDLE, FLOORS, MAN, ERASE).
- Sub-module man_sprite_rom: combinational/registered-free lookup, inputs style[1:0], row[3:0], col[2:0], output mask bit; four 8x16 frames.

## Test plan
- drawing_floors+writeEn held from reset -> exactly 480 plots, rows {39,79,119}, cols 0..159, FLOOR_COLOUR, finish high after edge 480, held until request drops.
- ld_x/ld_y/ld_man_style with (20,50,1), then draw_man -> plots only inside x20..27, y50..65 matching ROM frame 1; finish after edge 128.
- Load x=156 then erase -> 128 cycles to finish, only cols 156..159 plotted (4x16=64 plots), BG_COLOUR.
- writeEn toggled 1/0 every cycle during man draw -> finish after edge 256, no pixel duplicated or skipped.
- erase raised during floors scan at pixel 100 -> floor scan abandoned, erase starts offset 0; reset_n pulse mid-erase -> all outputs 0, latches back to (8,23,0).
- Build with and without MAN_TRANSPARENCY_EN, style 0 draw -> plot count equals ROM popcount vs 128.

Source files
------------

// File: rtl/runner_pkg.sv
// runner_pkg
//   Shared constants and types for the running-man pixel datapath:
//   screen geometry, floor rows, colour codes, the drawing-mode enum and
//   a helper mapping floor index to screen row.
package runner_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    localparam logic [6:0] FLOOR_ROW0 = 7'd39;
    localparam logic [6:0] FLOOR_ROW1 = 7'd79;
    localparam logic [6:0] FLOOR_ROW2 = 7'd119;

    localparam logic [2:0] FLOOR_COLOUR = 3'b010;
    localparam logic [2:0] MAN_COLOUR   = 3'b111;
    localparam logic [2:0] BG_COLOUR    = 3'b000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLOORS = 2'd1,
        MAN    = 2'd2,
        ERASE  = 2'd3
    } mode_e;

    function automatic logic [6:0] floor_row(input logic [1:0] idx);
        case (idx)
            2'd0:    floor_row = FLOOR_ROW0;
            2'd1:    floor_row = FLOOR_ROW1;
            default: floor_row = FLOOR_ROW2;
        endcase
    endfunction

endpackage

// File: rtl/man_sprite_rom.sv
// man_sprite_rom
//   Combinational lookup of the running-man sprite mask: four animation
//   frames, each 8 columns x 16 rows. Column 0 is the leftmost pixel and
//   maps to the MSB of each stored row byte.
// Ports:
//   i_style [1:0]  animation frame select
//   i_row   [3:0]  sprite row (0 = top)
//   i_col   [2:0]  sprite column (0 = left)
//   o_mask         1 = man pixel, 0 = background
module man_sprite_rom (
    input  logic [1:0] i_style,
    input  logic [3:0] i_row,
    input  logic [2:0] i_col,
    output logic       o_mask
);

    localparam logic [7:0] FRAMES [4][16] = '{
        '{8'h18, 8'h3C, 8'h3C, 8'h18, 8'h7E, 8'hFF, 8'hBD, 8'hBD,
          8'h3C, 8'h24, 8'h24, 8'h24, 8'h24, 8'h24, 8'h66, 8'h66},
        '{8'h18, 8'h3C, 8'h3C, 8'h18, 8'h3E, 8'h7D, 8'hB9, 8'h38,
          8'h3C, 8'h26, 8'h22, 8'h43, 8'h41, 8'h81, 8'hC0, 8'h00},
        '{8'h18, 8'h3C, 8'h3C, 8'h18, 8'h7C, 8'hBE, 8'h9D, 8'h1C,
          8'h3C, 8'h64, 8'h44, 8'hC2, 8'h82, 8'h81, 8'h03, 8'h00},
        '{8'h18, 8'h3C, 8'h3C, 8'h18, 8'h3C, 8'h7E, 8'h3C, 8'h3C,
          8'h18, 8'h18, 8'h1C, 8'h14, 8'h24, 8'h24, 8'h6C, 8'h00}
    };

    logic [7:0] w_row_bits;

    assign w_row_bits = FRAMES[i_style][i_row];
    // ~col == 7 - col for a 3-bit column: column 0 selects the MSB
    assign o_mask     = w_row_bits[~i_col];

endmodule

// File: rtl/runner_draw_datapath.sv
// runner_draw_datapath
//   Pixel generator for the running-man game. Arbitrates the control
//   FSM's level requests (drawing_floors > erase > draw_man), scans the
//   selected region one coordinate per writeEn-high cycle and emits a
//   registered pixel to the 160x120 3-bit VGA adapter, raising the mode's
//   finish level with the last pixel until the request drops.
// Build option:
//   MAN_TRANSPARENCY_EN  when defined, mask-0 sprite pixels are not
//                        plotted; otherwise they are plotted in BG_COLOUR.
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   drawing_floors, draw_man, erase   mode requests (level)
//   writeEn                           pixel advance enable (low = stall)
//   ld_x, ld_y, ld_man_style          latch man_x_in/man_y_in/man_style_in
//   man_x_in, man_y_in, man_style_in  sprite position and frame
//   vga_x, vga_y, vga_colour, vga_plot  pixel to the VGA adapter
//   draw_floors_finish, draw_man_finish, erase_finish  completion levels
module runner_draw_datapath #(
    parameter int unsigned SCREEN_W   = runner_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H   = runner_pkg::SCREEN_H,
    parameter int unsigned SPRITE_W   = 8,
    parameter int unsigned SPRITE_H   = 16,
    parameter logic [7:0]  MAN_X_INIT = 8'd8,
    parameter logic [6:0]  MAN_Y_INIT = 7'd23
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       drawing_floors,
    input  logic       draw_man,
    input  logic       erase,
    input  logic       writeEn,
    input  logic       ld_x,
    input  logic       ld_y,
    input  logic       ld_man_style,
    input  logic [7:0] man_x_in,
    input  logic [6:0] man_y_in,
    input  logic [1:0] man_style_in,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       draw_floors_finish,
    output logic       draw_man_finish,
    output logic       erase_finish
);

    import runner_pkg::mode_e;
    import runner_pkg::IDLE;
    import runner_pkg::FLOORS;
    import runner_pkg::MAN;
    import runner_pkg::ERASE;
    import runner_pkg::FLOOR_COLOUR;
    import runner_pkg::MAN_COLOUR;
    import runner_pkg::BG_COLOUR;
    import runner_pkg::floor_row;

    mode_e      r_mode;
    mode_e      w_mode;

    logic [7:0] r_col;
    logic [6:0] r_row;
    logic [7:0] r_man_x;
    logic [6:0] r_man_y;
    logic [1:0] r_style;

    logic [7:0] r_vga_x;
    logic [6:0] r_vga_y;
    logic [2:0] r_vga_colour;
    logic       r_vga_plot;
    logic       r_fin_floors;
    logic       r_fin_man;
    logic       r_fin_erase;

    logic       w_done;
    logic       w_mask;
    logic [8:0] w_px;
    logic [7:0] w_py;
    logic [2:0] w_colour;
    logic       w_plot;
    logic [7:0] w_last_col;
    logic [6:0] w_last_row;

    man_sprite_rom u_rom (
        .i_style (r_style),
        .i_row   (r_row[3:0]),
        .i_col   (r_col[2:0]),
        .o_mask  (w_mask)
    );

    always_comb begin
        w_mode = IDLE;
        if (drawing_floors)
            w_mode = FLOORS;
        else if (erase)
            w_mode = ERASE;
        else if (draw_man)
            w_mode = MAN;
    end

    assign w_done     = r_fin_floors | r_fin_man | r_fin_erase;
    assign w_last_col = (r_mode == FLOORS) ? 8'(SCREEN_W - 1) : 8'(SPRITE_W - 1);
    assign w_last_row = (r_mode == FLOORS) ? 7'd2 : 7'(SPRITE_H - 1);

    // Pixel for the current scan offset; coordinates are one bit wider
    // than the screen so a box hanging off the edge clips instead of wrapping.
    always_comb begin
        w_px     = '0;
        w_py     = '0;
        w_colour = BG_COLOUR;
        w_plot   = 1'b0;
        case (r_mode)
            FLOORS: begin
                w_px     = {1'b0, r_col};
                w_py     = {1'b0, floor_row(r_row[1:0])};
                w_colour = FLOOR_COLOUR;
                w_plot   = 1'b1;
            end
            MAN: begin
                w_px = {1'b0, r_man_x} + {1'b0, r_col};
                w_py = {1'b0, r_man_y} + {1'b0, r_row};
`ifdef MAN_TRANSPARENCY_EN
                w_colour = MAN_COLOUR;
                w_plot   = w_mask;
`else
                w_colour = w_mask ? MAN_COLOUR : BG_COLOUR;
                w_plot   = 1'b1;
`endif
            end
            ERASE: begin
                w_px     = {1'b0, r_man_x} + {1'b0, r_col};
                w_py     = {1'b0, r_man_y} + {1'b0, r_row};
                w_colour = BG_COLOUR;
                w_plot   = 1'b1;
            end
            default: ;
        endcase
        if (w_px >= 9'(SCREEN_W) || w_py >= 8'(SCREEN_H))
            w_plot = 1'b0;
    end

    // The mode is registered one edge ahead of the scan: the edge that
    // first sees a new request only clears the counter, so offset 0 is
    // issued on the following edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode       <= IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
            r_vga_plot   <= 1'b0;
            r_fin_floors <= 1'b0;
            r_fin_man    <= 1'b0;
            r_fin_erase  <= 1'b0;
        end else begin
            r_mode <= w_mode;
            if (w_mode != r_mode) begin
                r_col        <= '0;
                r_row        <= '0;
                r_vga_plot   <= 1'b0;
                r_fin_floors <= 1'b0;
                r_fin_man    <= 1'b0;
                r_fin_erase  <= 1'b0;
            end else if (r_mode != IDLE && writeEn && !w_done) begin
                r_vga_x      <= w_px[7:0];
                r_vga_y      <= w_py[6:0];
                r_vga_colour <= w_colour;
                r_vga_plot   <= w_plot;
                if (r_col == w_last_col) begin
                    if (r_row == w_last_row) begin
                        r_fin_floors <= (r_mode == FLOORS);
                        r_fin_man    <= (r_mode == MAN);
                        r_fin_erase  <= (r_mode == ERASE);
                    end else begin
                        r_col <= '0;
                        r_row <= r_row + 7'd1;
                    end
                end else begin
                    r_col <= r_col + 8'd1;
                end
            end else begin
                r_vga_plot <= 1'b0;
            end
        end
    end

    // Sprite box is frozen while a man draw or erase is requested.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_man_x <= MAN_X_INIT;
            r_man_y <= MAN_Y_INIT;
            r_style <= '0;
        end else if (!draw_man && !erase) begin
            if (ld_x)
                r_man_x <= man_x_in;
            if (ld_y)
                r_man_y <= man_y_in;
            if (ld_man_style)
                r_style <= man_style_in;
        end
    end

    assign vga_x              = r_vga_x;
    assign vga_y              = r_vga_y;
    assign vga_colour         = r_vga_colour;
    assign vga_plot           = r_vga_plot;
    assign draw_floors_finish = r_fin_floors;
    assign draw_man_finish    = r_fin_man;
    assign erase_finish       = r_fin_erase;

endmodule

// File: tb/tb_runner_draw_datapath.sv
// tb_runner_draw_datapath
//   Self-checking bench: drives request/writeEn scenarios, collects every
//   plotted pixel and compares against a set-based reference of the region
//   each mode should paint, plus finish timing from writeEn-high counts.
module tb_runner_draw_datapath;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       drawing_floors, draw_man, erase, writeEn;
    logic       ld_x, ld_y, ld_man_style;
    logic [7:0] man_x_in;
    logic [6:0] man_y_in;
    logic [1:0] man_style_in;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       draw_floors_finish, draw_man_finish, erase_finish;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    runner_draw_datapath dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .drawing_floors     (drawing_floors),
        .draw_man           (draw_man),
        .erase              (erase),
        .writeEn            (writeEn),
        .ld_x               (ld_x),
        .ld_y               (ld_y),
        .ld_man_style       (ld_man_style),
        .man_x_in           (man_x_in),
        .man_y_in           (man_y_in),
        .man_style_in       (man_style_in),
        .vga_x              (vga_x),
        .vga_y              (vga_y),
        .vga_colour         (vga_colour),
        .vga_plot           (vga_plot),
        .draw_floors_finish (draw_floors_finish),
        .draw_man_finish    (draw_man_finish),
        .erase_finish       (erase_finish)
    );

    // Reference sprite art: row byte, MSB = leftmost column.
    logic [7:0] rom_t [4][16] = '{
        '{8'h18, 8'h3C, 8'h3C, 8'h18, 8'h7E, 8'hFF, 8'hBD, 8'hBD,
          8'h3C, 8'h24, 8'h24, 8'h24, 8'h24, 8'h24, 8'h66, 8'h66},
        '{8'h18, 8'h3C, 8'h3C, 8'h18, 8'h3E, 8'h7D, 8'hB9, 8'h38,
          8'h3C, 8'h26, 8'h22, 8'h43, 8'h41, 8'h81, 8'hC0, 8'h00},
        '{8'h18, 8'h3C, 8'h3C, 8'h18, 8'h7C, 8'hBE, 8'h9D, 8'h1C,
          8'h3C, 8'h64, 8'h44, 8'hC2, 8'h82, 8'h81, 8'h03, 8'h00},
        '{8'h18, 8'h3C, 8'h3C, 8'h18, 8'h3C, 8'h7E, 8'h3C, 8'h3C,
          8'h18, 8'h18, 8'h1C, 8'h14, 8'h24, 8'h24, 8'h6C, 8'h00}
    };

    // Expected painted set: key = x*256 + y, value = colour.
    logic [2:0] exp_map [int];
    int obs_x[$], obs_y[$], obs_c[$];

    // Modes: 1 floors, 2 man, 3 erase.
    function automatic void build_expected(input int mode, input int bx, input int by, input int st);
        logic [7:0] rb;
        exp_map.delete();
        if (mode == 1) begin
            for (int f = 0; f < 3; f++)
                for (int c = 0; c < 160; c++)
                    exp_map[c*256 + (40*f + 39)] = 3'b010;
        end else begin
            for (int r = 0; r < 16; r++) begin
                rb = rom_t[st][r];
                for (int c = 0; c < 8; c++) begin
                    if (bx + c < 160 && by + r < 120) begin
                        if (mode == 3)
                            exp_map[(bx+c)*256 + (by+r)] = 3'b000;
                        else if (rb[7-c])
                            exp_map[(bx+c)*256 + (by+r)] = 3'b111;
`ifndef MAN_TRANSPARENCY_EN
                        else
                            exp_map[(bx+c)*256 + (by+r)] = 3'b000;
`endif
                    end
                end
            end
        end
    endfunction

    // Plots outside the set, wrong colour, repeated, or never delivered.
    function automatic int plot_errors();
        int  err = 0;
        int  key;
        bit  seen [int];
        for (int i = 0; i < obs_x.size(); i++) begin
            key = obs_x[i]*256 + obs_y[i];
            if (!exp_map.exists(key))           err++;
            else if (exp_map[key] != obs_c[i])  err++;
            else if (seen.exists(key))          err++;
            else                                seen[key] = 1'b1;
        end
        return err + (exp_map.num() - seen.num());
    endfunction

    task automatic load_box(input int x, input int y, input int st);
        man_x_in = 8'(x); man_y_in = 7'(y); man_style_in = 2'(st);
        ld_x = 1'b1; ld_y = 1'b1; ld_man_style = 1'b1;
        @(posedge clk); #1;
        ld_x = 1'b0; ld_y = 1'b0; ld_man_style = 1'b0;
    endtask

    task automatic release_req();
        drawing_floors = 1'b0; draw_man = 1'b0; erase = 1'b0; writeEn = 1'b0;
        @(posedge clk); #1;
    endtask

    // Edge 0 is the first edge sampling the request; exp_fin is the edge
    // at which the n_coords-th writeEn-high sample (from edge 1) occurs.
    task automatic drive_scan(input int mode, input int wen_kind, input int n_coords,
                              input int n_edges, input bit glitch_ld,
                              output int fin_edge, output int exp_fin, output int fin_drops);
        int   hi = 0;
        logic fin;
        obs_x.delete(); obs_y.delete(); obs_c.delete();
        drawing_floors = (mode == 1); draw_man = (mode == 2); erase = (mode == 3);
        fin_edge = -1; exp_fin = -1; fin_drops = 0;
        for (int e = 0; e < n_edges; e++) begin
            case (wen_kind)
                0:       writeEn = 1'b1;
                1:       writeEn = (e % 2 == 0);
                default: writeEn = ($urandom_range(0, 3) != 0);
            endcase
            if (glitch_ld) begin
                ld_x = (e == 5); ld_y = (e == 5); ld_man_style = (e == 5);
                man_x_in = 8'($urandom); man_y_in = 7'($urandom); man_style_in = 2'($urandom);
            end
            if (e >= 1 && writeEn && hi < n_coords) begin
                hi++;
                if (hi == n_coords) exp_fin = e;
            end
            @(posedge clk); #1;
            if (vga_plot) begin
                obs_x.push_back(int'(vga_x)); obs_y.push_back(int'(vga_y)); obs_c.push_back(int'(vga_colour));
            end
            fin = (mode == 1) ? draw_floors_finish : (mode == 2) ? draw_man_finish : erase_finish;
            if (fin && fin_edge < 0) fin_edge = e;
            if (!fin && fin_edge >= 0) fin_drops++;
        end
        ld_x = 1'b0; ld_y = 1'b0; ld_man_style = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drawing_floors = 1'b0; draw_man = 1'b0; erase = 1'b0; writeEn = 1'b0;
        ld_x = 1'b0; ld_y = 1'b0; ld_man_style = 1'b0;
        man_x_in = '0; man_y_in = '0; man_style_in = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({vga_x, vga_y, vga_colour, vga_plot, draw_floors_finish, draw_man_finish, erase_finish} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: x=%0d y=%0d c=%0d plot=%b fin=%b%b%b, required all 0",
                     vga_x, vga_y, vga_colour, vga_plot, draw_floors_finish, draw_man_finish, erase_finish);
        end
    endtask

    task automatic test_floors();
        int fe, xf, drops;
        // request held across reset release
        drawing_floors = 1'b1; writeEn = 1'b1;
        reset_n = 1'b1;
        drive_scan(1, 0, 480, 490, 1'b0, fe, xf, drops);
        build_expected(1, 0, 0, 0);
        total++;
        if (obs_x.size() !== 480) begin bad++; $display("FAIL floors_count: got %0d, required 480", obs_x.size()); end
        total++;
        if (plot_errors() !== 0) begin bad++; $display("FAIL floors_pixels: %0d bad pixels, required 0", plot_errors()); end
        total++;
        if (fe !== xf || xf !== 480) begin bad++; $display("FAIL floors_finish_edge: got %0d, required %0d", fe, xf); end
        total++;
        if (drops !== 0) begin bad++; $display("FAIL floors_finish_hold: dropped %0d cycles, required 0", drops); end
        release_req();
        total++;
        if (draw_floors_finish !== 1'b0 || vga_plot !== 1'b0) begin
            bad++; $display("FAIL floors_release: fin=%b plot=%b, required 0 0", draw_floors_finish, vga_plot);
        end
    endtask

    task automatic test_man_frame1();
        int fe, xf, drops;
        load_box(20, 50, 1);
        drive_scan(2, 0, 128, 140, 1'b0, fe, xf, drops);
        build_expected(2, 20, 50, 1);
        total++;
        if (plot_errors() !== 0) begin bad++; $display("FAIL man1_pixels: %0d bad pixels, required 0", plot_errors()); end
        total++;
        if (obs_x.size() !== exp_map.num()) begin bad++; $display("FAIL man1_count: got %0d, required %0d", obs_x.size(), exp_map.num()); end
        total++;
        if (fe !== 128) begin bad++; $display("FAIL man1_finish_edge: got %0d, required 128", fe); end
        total++;
        if (drops !== 0) begin bad++; $display("FAIL man1_finish_hold: dropped %0d, required 0", drops); end
        release_req();
        total++;
        if (draw_man_finish !== 1'b0) begin bad++; $display("FAIL man1_release: fin=%b, required 0", draw_man_finish); end
    endtask

    task automatic test_erase_clip();
        int fe, xf, drops;
        load_box(156, 60, 2);
        drive_scan(3, 0, 128, 140, 1'b0, fe, xf, drops);
        build_expected(3, 156, 60, 2);
        total++;
        if (obs_x.size() !== 64) begin bad++; $display("FAIL erase_clip_count: got %0d, required 64", obs_x.size()); end
        total++;
        if (plot_errors() !== 0) begin bad++; $display("FAIL erase_clip_pixels: %0d bad, required 0", plot_errors()); end
        total++;
        if (fe !== 128) begin bad++; $display("FAIL erase_clip_finish_edge: got %0d, required 128", fe); end
        release_req();
    endtask

    task automatic test_stall();
        int fe, xf, drops;
        load_box(60, 70, 3);
        drive_scan(2, 1, 128, 270, 1'b0, fe, xf, drops);
        build_expected(2, 60, 70, 3);
        total++;
        if (plot_errors() !== 0) begin bad++; $display("FAIL stall_pixels: %0d bad, required 0", plot_errors()); end
        total++;
        if (fe !== xf || xf !== 256) begin bad++; $display("FAIL stall_finish_edge: got %0d, required %0d", fe, xf); end
        total++;
        if (drops !== 0) begin bad++; $display("FAIL stall_finish_hold: dropped %0d, required 0", drops); end
        release_req();
    endtask

    task automatic test_random();
        int fe, xf, drops, bx, by, st, md;
        for (int it = 0; it < 6; it++) begin
            bx = $urandom_range(0, 255); by = $urandom_range(0, 127);
            st = $urandom_range(0, 3);   md = $urandom_range(2, 3);
            load_box(bx, by, st);
            drive_scan(md, 2, 128, 400, 1'b1, fe, xf, drops);
            build_expected(md, bx, by, st);
            total++;
            if (plot_errors() !== 0) begin
                bad++; $display("FAIL rand%0d_pixels: mode=%0d box=(%0d,%0d,%0d) %0d bad, required 0", it, md, bx, by, st, plot_errors());
            end
            total++;
            if (fe !== xf || xf < 0) begin bad++; $display("FAIL rand%0d_finish_edge: got %0d, required %0d", it, fe, xf); end
            release_req();
        end
    endtask

    task automatic test_preempt_reset();
        int fe, xf, drops, pop, outside;
        load_box(40, 30, 2);
        drive_scan(1, 0, 480, 101, 1'b0, fe, xf, drops);
        build_expected(1, 0, 0, 0);
        outside = 0;
        foreach (obs_x[i]) if (!exp_map.exists(obs_x[i]*256 + obs_y[i])) outside++;
        total++;
        if (obs_x.size() !== 100 || outside !== 0) begin
            bad++; $display("FAIL preempt_floor_part: plots=%0d outside=%0d, required 100 0", obs_x.size(), outside);
        end
        drive_scan(3, 0, 128, 135, 1'b0, fe, xf, drops);
        build_expected(3, 40, 30, 2);
        total++;
        if (plot_errors() !== 0) begin bad++; $display("FAIL preempt_erase_pixels: %0d bad, required 0", plot_errors()); end
        total++;
        if (fe !== 128) begin bad++; $display("FAIL preempt_erase_finish_edge: got %0d, required 128", fe); end
        release_req();
        drive_scan(3, 0, 128, 50, 1'b0, fe, xf, drops);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({vga_x, vga_y, vga_colour, vga_plot, draw_floors_finish, draw_man_finish, erase_finish} !== '0) begin
            bad++; $display("FAIL midscan_reset: x=%0d y=%0d c=%0d plot=%b fin=%b, required all 0",
                            vga_x, vga_y, vga_colour, vga_plot, erase_finish);
        end
        erase = 1'b0; writeEn = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        // latches must be back to (8,23,0): draw frame 0 there
        drive_scan(2, 0, 128, 135, 1'b0, fe, xf, drops);
        build_expected(2, 8, 23, 0);
        pop = 0;
        for (int r = 0; r < 16; r++) for (int c = 0; c < 8; c++) pop += int'(rom_t[0][r][c]);
        total++;
        if (plot_errors() !== 0) begin bad++; $display("FAIL reset_latch_pixels: %0d bad, required 0", plot_errors()); end
        total++;
`ifdef MAN_TRANSPARENCY_EN
        if (obs_x.size() !== pop) begin bad++; $display("FAIL style0_plot_count: got %0d, required %0d", obs_x.size(), pop); end
`else
        if (obs_x.size() !== 128) begin bad++; $display("FAIL style0_plot_count: got %0d, required 128 (popcount %0d)", obs_x.size(), pop); end
`endif
        total++;
        if (fe !== 128) begin bad++; $display("FAIL reset_latch_finish_edge: got %0d, required 128", fe); end
        release_req();
    endtask

    initial begin
        test_reset();
        test_floors();
        test_man_frame1();
        test_erase_clip();
        test_stall();
        test_random();
        test_preempt_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
